axis_stall_monitor: RTL and testbench
=====================================

AXIS_STALL_MONITOR -- requirements
Module: axis_stall_monitor

Interface
REQ-001 SHALL provide parameter NUM_CH, default 5, meaning the number of monitored AXIS channels (1..32).
REQ-002 SHALL provide parameter TIMEOUT, default 1024, meaning the consecutive blocked cycles before deadlock is declared (2..2^CNT_W-1).
REQ-003 SHALL provide parameter CNT_W, default 16, meaning the run-counter width.
REQ-004 SHALL derive CH_W = max(1, clog2(NUM_CH)) internally.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 block_sigs  input  NUM_CH  per-channel AXIS blocked indication.
REQ-008 idle_sigs  input  NUM_CH  per-channel idle; an idle channel is masked out.
REQ-009 clear  input  1  one-cycle pulse; releases a latched deadlock.
REQ-010 block  output  1  deadlock declared (latched).
REQ-011 block_info  output  NUM_CH  snapshot of effective blocked channels at declaration.
REQ-012 first_ch  output  CH_W  lowest-index channel blocked when the current run began.
REQ-013 run_cnt  output  CNT_W  current consecutive blocked-cycle count.
REQ-014 dl_count  output  8  number of deadlocks declared since reset.
REQ-015 max_stall  output  CNT_W  longest blocked run since reset or clear (see Configuration).

Function
REQ-016 SHALL compute eff = block_sigs & ~idle_sigs and any_blk = OR of eff, combinationally, each cycle.
REQ-017 SHALL implement states IDLE, WATCH and DEADLOCK.
REQ-018 In IDLE, when any_blk = 1, SHALL go to WATCH, set run_cnt to 1, and load first_ch with the lowest set index of eff.
REQ-019 In WATCH, when any_blk = 0, SHALL return to IDLE with run_cnt = 0; a run that changes channels without a gap SHALL count as continuous.
REQ-020 In WATCH, when any_blk = 1 and run_cnt = TIMEOUT-1, SHALL go to DEADLOCK, set run_cnt to TIMEOUT, load block_info with eff, and set block = 1 (visible the cycle after the TIMEOUT-th consecutive blocked cycle).
REQ-021 In WATCH, any other blocked cycle SHALL increment run_cnt.
REQ-022 In DEADLOCK, block, block_info and first_ch SHALL hold regardless of block_sigs.
REQ-023 In DEADLOCK, run_cnt SHALL increment while any_blk = 1, hold when any_blk = 0, and saturate at 2^CNT_W-1.
REQ-024 dl_count SHALL increment by 1 on each WATCH-to-DEADLOCK transition and saturate at 255; clear SHALL NOT affect it.
REQ-025 clear in any state SHALL force IDLE and zero block, block_info, first_ch and run_cnt next cycle.
REQ-026 When clear and any_blk are asserted in the same cycle, clear SHALL win and that cycle's eff SHALL be ignored.
REQ-027 When all blocked channels are also idle, SHALL treat the cycle as unblocked.

Reset
REQ-028 On reset = 1 at a clock edge, SHALL enter IDLE with block = 0, block_info = 0, first_ch = 0, run_cnt = 0, dl_count = 0 and max_stall = 0.
REQ-029 reset SHALL take priority over clear and all inputs; reset mid-run SHALL discard the run with no dl_count increment.

Configuration
REQ-030 With macro AXIS_STALL_MON_MAXLEN_EN defined, max_stall SHALL update to run_cnt whenever the registered run_cnt exceeds it.
REQ-031 With AXIS_STALL_MON_MAXLEN_EN defined, max_stall SHALL be zeroed by reset and by clear.
REQ-032 Without AXIS_STALL_MON_MAXLEN_EN, max_stall SHALL be constant 0 and SHALL have no register.

Verification (NUM_CH=5, TIMEOUT=8, CNT_W=16)
REQ-033 block_sigs = 5'b00100 for 8 cycles -> block = 1 on the 9th cycle, block_info = 5'b00100, first_ch = 2, dl_count = 1.
REQ-034 block_sigs = 5'b00010 for 7 cycles, then 0 for 1 cycle, then 5'b00010 for 7 cycles -> block stays 0 throughout and run_cnt returns to 0 at the gap.
REQ-035 block_sigs = 5'b01000 for 4 cycles then 5'b10000 for 4 cycles -> block = 1, first_ch = 3, block_info = 5'b10000.
REQ-036 block_sigs = 5'b00001 with idle_sigs = 5'b00001 for 20 cycles -> block = 0 and run_cnt = 0.
REQ-037 Deadlock latched, then clear pulsed with block_sigs still 5'b00001 -> all outputs zero next cycle except dl_count = 1; the new run starts the following cycle and redeclares after 8 more blocked cycles with dl_count = 2.
REQ-038 With AXIS_STALL_MON_MAXLEN_EN, run of 5 cycles, gap, run of 3 cycles -> max_stall = 5; reset asserted mid-run -> all outputs 0.

Source files
------------

// File: rtl/axis_stall_monitor.sv
// AXI-Stream stall/deadlock monitor: declares deadlock after TIMEOUT consecutive blocked cycles.
// Optional AXIS_STALL_MON_MAXLEN_EN enables the longest-run (max_stall) register.
module axis_stall_monitor #(
    parameter int NUM_CH  = 5,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] block_sigs,
    input  logic [NUM_CH-1:0] idle_sigs,
    input  logic              clear,
    output logic              block,
    output logic [NUM_CH-1:0] block_info,
    output logic [CH_W-1:0]   first_ch,
    output logic [CNT_W-1:0]  run_cnt,
    output logic [7:0]        dl_count,
    output logic [CNT_W-1:0]  max_stall
);

    typedef enum logic [1:0] {IDLE, WATCH, DEADLOCK} state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] eff;
    logic              any_blk;
    logic [CH_W-1:0]   low_idx;
    logic              low_found;

    logic              block_nxt;
    logic [NUM_CH-1:0] block_info_nxt;
    logic [CH_W-1:0]   first_ch_nxt;
    logic [CNT_W-1:0]  run_cnt_nxt;
    logic [7:0]        dl_count_nxt;

    assign eff     = block_sigs & ~idle_sigs;
    assign any_blk = |eff;

    always_comb begin
        low_idx   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (eff[i] && !low_found) begin
                low_idx   = CH_W'(i);
                low_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        block_nxt      = block;
        block_info_nxt = block_info;
        first_ch_nxt   = first_ch;
        run_cnt_nxt    = run_cnt;
        dl_count_nxt   = dl_count;
        if (clear) begin
            state_nxt      = IDLE;
            block_nxt      = 1'b0;
            block_info_nxt = '0;
            first_ch_nxt   = '0;
            run_cnt_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_blk) begin
                        state_nxt    = WATCH;
                        run_cnt_nxt  = CNT_W'(1);
                        first_ch_nxt = low_idx;
                    end
                end
                WATCH: begin
                    if (!any_blk) begin
                        state_nxt   = IDLE;
                        run_cnt_nxt = '0;
                    end else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state_nxt      = DEADLOCK;
                        run_cnt_nxt    = CNT_W'(TIMEOUT);
                        block_info_nxt = eff;
                        block_nxt      = 1'b1;
                        if (dl_count != 8'hFF) dl_count_nxt = dl_count + 8'd1;
                    end else begin
                        run_cnt_nxt = run_cnt + CNT_W'(1);
                    end
                end
                DEADLOCK: begin
                    if (any_blk && (run_cnt != '1)) run_cnt_nxt = run_cnt + CNT_W'(1);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            block      <= 1'b0;
            block_info <= '0;
            first_ch   <= '0;
            run_cnt    <= '0;
            dl_count   <= '0;
        end else begin
            state      <= state_nxt;
            block      <= block_nxt;
            block_info <= block_info_nxt;
            first_ch   <= first_ch_nxt;
            run_cnt    <= run_cnt_nxt;
            dl_count   <= dl_count_nxt;
        end
    end

`ifdef AXIS_STALL_MON_MAXLEN_EN
    logic [CNT_W-1:0] max_q;

    // Tracks the registered run_cnt, so it trails the counter by one cycle.
    always_ff @(posedge clock) begin
        if (reset || clear) max_q <= '0;
        else if (run_cnt > max_q) max_q <= run_cnt;
    end

    assign max_stall = max_q;
`else
    assign max_stall = '0;
`endif

endmodule

// File: tb/tb_axis_stall_monitor.sv
// Self-checking bench for axis_stall_monitor (NUM_CH=5, TIMEOUT=8, CNT_W=16): directed cases plus random stimulus.
module tb_axis_stall_monitor;

    localparam int NUM_CH  = 5;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NUM_CH-1:0] block_sigs = '0;
    logic [NUM_CH-1:0] idle_sigs = '0;
    logic              clear = 1'b0;
    logic              block;
    logic [NUM_CH-1:0] block_info;
    logic [2:0]        first_ch;
    logic [CNT_W-1:0]  run_cnt;
    logic [7:0]        dl_count;
    logic [CNT_W-1:0]  max_stall;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    // Reference model: run length as a plain integer plus a latched flag.
    int          m_run   = 0;
    bit          m_lat   = 0;
    int          m_info  = 0;
    int          m_first = 0;
    int          m_dl    = 0;
    int          m_max   = 0;

    axis_stall_monitor #(
        .NUM_CH (NUM_CH),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .block_sigs(block_sigs),
        .idle_sigs (idle_sigs),
        .clear     (clear),
        .block     (block),
        .block_info(block_info),
        .first_ch  (first_ch),
        .run_cnt   (run_cnt),
        .dl_count  (dl_count),
        .max_stall (max_stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [4:0] b, input logic [4:0] i, input logic c, input logic r);
        logic [4:0] eff;
        logic [4:0] lsb;
        int         old_run;
        block_sigs = b;
        idle_sigs  = i;
        clear      = c;
        reset      = r;
        @(posedge clock);
        old_run = m_run;
        if (r) begin
            m_run = 0; m_lat = 0; m_info = 0; m_first = 0; m_dl = 0; m_max = 0;
        end else if (c) begin
            m_run = 0; m_lat = 0; m_info = 0; m_first = 0; m_max = 0;
        end else begin
            eff = b & ~i;
            if (m_lat) begin
                if (eff != 0 && m_run < 65535) m_run++;
            end else if (eff == 0) begin
                m_run = 0;
            end else begin
                if (m_run == 0) begin
                    lsb     = eff & (~eff + 5'd1);
                    m_first = $clog2(lsb);
                end
                m_run++;
                if (m_run == TIMEOUT) begin
                    m_lat  = 1;
                    m_info = eff;
                    if (m_dl < 255) m_dl++;
                end
            end
            if (old_run > m_max) m_max = old_run;
        end
        #1;
        check("block", 32'(block), 32'(m_lat));
        check("block_info", 32'(block_info), 32'(m_info));
        check("first_ch", 32'(first_ch), 32'(m_first));
        check("run_cnt", 32'(run_cnt), 32'(m_run));
        check("dl_count", 32'(dl_count), 32'(m_dl));
`ifdef AXIS_STALL_MON_MAXLEN_EN
        check("max_stall", 32'(max_stall), 32'(m_max));
`else
        check("max_stall", 32'(max_stall), 32'd0);
`endif
    endtask

    initial begin
        logic [4:0] b, i;
        int         len;
        int         r;

        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
        check("reset_block", 32'(block), 32'd0);
        check("reset_dl", 32'(dl_count), 32'd0);

        // Single channel stalled for TIMEOUT cycles.
        repeat (8) step(5'b00100, '0, 1'b0, 1'b0);
        check("d1_block", 32'(block), 32'd1);
        check("d1_info", 32'(block_info), 32'b00100);
        check("d1_first", 32'(first_ch), 32'd2);
        check("d1_dl", 32'(dl_count), 32'd1);
        step('0, '0, 1'b1, 1'b0);

        // One-cycle gap restarts the count.
        repeat (7) step(5'b00010, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        check("d2_gap_run", 32'(run_cnt), 32'd0);
        repeat (7) step(5'b00010, '0, 1'b0, 1'b0);
        check("d2_block", 32'(block), 32'd0);
        step('0, '0, 1'b0, 1'b0);

        // Channel hand-over without a gap stays one run.
        repeat (4) step(5'b01000, '0, 1'b0, 1'b0);
        repeat (4) step(5'b10000, '0, 1'b0, 1'b0);
        check("d3_block", 32'(block), 32'd1);
        check("d3_first", 32'(first_ch), 32'd3);
        check("d3_info", 32'(block_info), 32'b10000);

        // Clear while still blocked, then redeclare.
        step(5'b00001, '0, 1'b1, 1'b0);
        check("d4_clr_block", 32'(block), 32'd0);
        check("d4_clr_dl", 32'(dl_count), 32'd2);
        repeat (7) step(5'b00001, '0, 1'b0, 1'b0);
        check("d4_pre_block", 32'(block), 32'd0);
        step(5'b00001, '0, 1'b0, 1'b0);
        check("d4_block", 32'(block), 32'd1);
        check("d4_dl", 32'(dl_count), 32'd3);
        step('0, '0, 1'b1, 1'b0);

        // Blocked channel masked by idle.
        repeat (20) step(5'b00001, 5'b00001, 1'b0, 1'b0);
        check("d5_block", 32'(block), 32'd0);
        check("d5_run", 32'(run_cnt), 32'd0);

        // Longest run tracking, then reset mid-run.
        step('0, '0, 1'b0, 1'b1);
        repeat (5) step(5'b00001, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        repeat (3) step(5'b00001, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
`ifdef AXIS_STALL_MON_MAXLEN_EN
        check("d6_max", 32'(max_stall), 32'd5);
`else
        check("d6_max", 32'(max_stall), 32'd0);
`endif
        repeat (3) step(5'b00001, '0, 1'b0, 1'b0);
        step(5'b00001, '0, 1'b0, 1'b1);
        check("d6_rst_run", 32'(run_cnt), 32'd0);
        check("d6_rst_max", 32'(max_stall), 32'd0);

        // Random segments of held patterns with occasional clear/reset.
        for (int seg = 0; seg < 500; seg++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(5'($urandom), 5'($urandom), 1'($urandom), 1'b1);
            end else if (r < 8) begin
                step(5'($urandom), 5'($urandom), 1'b1, 1'b0);
            end else begin
                b   = ($urandom_range(0, 9) < 3) ? 5'd0 : 5'($urandom_range(1, 31));
                i   = ($urandom_range(0, 9) < 7) ? 5'd0 : 5'($urandom);
                len = $urandom_range(1, 12);
                for (int k = 0; k < len; k++) step(b, i, 1'b0, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
